// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared fetch-path types, constants and address helper
package proc_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_KEEP,
    PC_INC,
    PC_TARGET,
    PC_REDIR
  } pc_sel_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory and decode handshake bundle
interface fetch_sequencer_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );

endinterface

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - next-PC select over pc+4, branch target and deferred redirect
module fetch_pc_next
  import proc_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_target,
  input  logic [31:0] i_redir_pc,
  input  pc_sel_t     i_sel,
  output logic [31:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    case (i_sel)
      PC_INC:    o_pc_next = i_pc + 32'(INSTR_BYTES);
      PC_TARGET: o_pc_next = i_target;
      PC_REDIR:  o_pc_next = i_redir_pc;
      default:   o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner issuing single-outstanding fetches with branch redirect
// FETCH_MISALIGN_EN adds the sticky misaligned-target flag and the HALT state.
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              branch_taken_i,
  input  logic [31:0]       branch_target_i,
`ifdef FETCH_MISALIGN_EN
  output logic              fetch_misaligned_o,
`endif
  fetch_sequencer_if.master bus
);

  fetch_state_t r_state, w_state_n;
  logic [31:0]  r_pc, w_pc_n, r_redir_pc, w_redir_pc_n, r_instr, r_instr_pc, w_target;
  logic         r_discard, w_discard_n, r_redir_pend, w_redir_pend_n;
  logic         r_halt_pend, w_halt_pend_n, r_req, r_instr_valid, w_capture, w_bad;
  pc_sel_t      w_pc_sel;

  assign w_target = align_word(branch_target_i);

`ifdef FETCH_MISALIGN_EN
  logic r_misaligned;
  assign w_bad = branch_taken_i && (branch_target_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      r_misaligned <= 1'b0;
    else if (w_bad) r_misaligned <= 1'b1;
  end

  assign fetch_misaligned_o = r_misaligned;
`else
  assign w_bad = 1'b0;
`endif

  fetch_pc_next u_pc_next (
    .i_pc       (r_pc),
    .i_target   (w_target),
    .i_redir_pc (r_redir_pc),
    .i_sel      (w_pc_sel),
    .o_pc_next  (w_pc_n)
  );

  always_comb begin
    w_state_n      = r_state;
    w_pc_sel       = PC_KEEP;
    w_discard_n    = r_discard;
    w_redir_pend_n = r_redir_pend;
    w_redir_pc_n   = r_redir_pc;
    w_halt_pend_n  = r_halt_pend;
    w_capture      = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_n = REQ;
        if (w_bad)               w_state_n = HALT;
        else if (branch_taken_i) w_pc_sel  = PC_TARGET;
      end
      REQ: begin
        if (bus.imem_gnt_i) begin
          w_redir_pend_n = 1'b0;
          if (r_halt_pend || w_bad) begin
            w_state_n = HALT;
          end else begin
            // The granted word is wrong-path if any redirect landed while waiting for grant.
            w_state_n   = WAIT;
            w_discard_n = branch_taken_i || r_redir_pend;
            if (branch_taken_i)    w_pc_sel = PC_TARGET;
            else if (r_redir_pend) w_pc_sel = PC_REDIR;
          end
        end else if (w_bad) begin
          w_halt_pend_n = 1'b1;
        end else if (branch_taken_i) begin
          w_redir_pend_n = 1'b1;
          w_redir_pc_n   = w_target;
        end
      end
      WAIT: begin
        if (w_bad) begin
          w_state_n = HALT;
        end else if (branch_taken_i) begin
          w_pc_sel = PC_TARGET;
          if (bus.imem_rvalid_i) begin
            w_state_n   = REQ;
            w_discard_n = 1'b0;
          end else begin
            w_discard_n = 1'b1;
          end
        end else if (bus.imem_rvalid_i) begin
          if (r_discard) begin
            w_state_n   = REQ;
            w_discard_n = 1'b0;
          end else begin
            w_state_n = HOLD;
            w_capture = 1'b1;
            w_pc_sel  = PC_INC;
          end
        end
      end
      HOLD: begin
        if (w_bad) begin
          w_state_n = HALT;
        end else if (branch_taken_i) begin
          w_state_n = REQ;
          w_pc_sel  = PC_TARGET;
        end else if (bus.instr_ready_i) begin
          w_state_n = REQ;
        end
      end
      HALT:    w_state_n = HALT;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_discard     <= 1'b0;
      r_redir_pend  <= 1'b0;
      r_redir_pc    <= 32'h0;
      r_halt_pend   <= 1'b0;
      r_req         <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_discard     <= w_discard_n;
      r_redir_pend  <= w_redir_pend_n;
      r_redir_pc    <= w_redir_pc_n;
      r_halt_pend   <= w_halt_pend_n;
      r_req         <= (w_state_n == REQ);
      r_instr_valid <= (w_state_n == HOLD);
      if (w_capture) begin
        r_instr    <= bus.imem_rdata_i;
        r_instr_pc <= r_pc;
      end
    end
  end

  assign bus.imem_req_o    = r_req;
  assign bus.imem_addr_o   = r_pc;
  assign bus.instr_valid_o = r_instr_valid;
  assign bus.instr_o       = r_instr;
  assign bus.instr_pc_o    = r_instr_pc;

endmodule
